// File: rtl/dw_dbp_pkg.sv
// Shared definitions for the debug-APB authentication gate: FSM encoding,
// status counter width and the read data returned for a denied transfer.
package dw_dbp_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FSETUP = 3'd1;
   localparam logic [2:0] ST_FACC   = 3'd2;
   localparam logic [2:0] ST_RESP   = 3'd3;
   localparam logic [2:0] ST_DENY   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FSETUP = ST_FSETUP,
      S_FACC   = ST_FACC,
      S_RESP   = ST_RESP,
      S_DENY   = ST_DENY
   } state_e;

   localparam int          DENY_CNT_W = 8;
   localparam logic [31:0] DENY_RDATA = 32'h0000_0000;

endpackage

// File: rtl/dw_dbp_sync2.sv
// Two-flop synchroniser for a level signal crossing into clk; resets to 0.
module dw_dbp_sync2
   import dw_dbp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_d;
   logic [1:0] sync_q;

   // shift the asynchronous level through two stages
   always_comb begin
      sync_d = {sync_q[0], d};
   end

   // synchroniser flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/dw_dbp_apb_auth_gate.sv
// Debug-APB authentication gate: forwards permitted transfers to the debug
// target, answers denied ones locally with PSLVERR, and bounds a hung target.
module dw_dbp_apb_auth_gate
   import dw_dbp_pkg::*;
#(
   parameter int            AW        = 12,
   parameter logic [AW-1:0] INV_MASK  = 12'hF00,
   parameter logic [AW-1:0] INV_MATCH = 12'h000,
   parameter int            TIMEOUT   = 255
) (
   input  logic                  clk,
   input  logic                  dbg_apb_presetn,
   input  logic                  dbg_apb_dbgen,
   input  logic                  dbg_apb_niden,
   input  logic                  s_psel,
   input  logic                  s_penable,
   input  logic                  s_pwrite,
   input  logic [AW-1:0]         s_paddr,
   input  logic [31:0]           s_pwdata,
   output logic [31:0]           s_prdata,
   output logic                  s_pready,
   output logic                  s_pslverr,
   output logic                  m_psel,
   output logic                  m_penable,
   output logic                  m_pwrite,
   output logic [AW-1:0]         m_paddr,
   output logic [31:0]           m_pwdata,
   input  logic [31:0]           m_prdata,
   input  logic                  m_pready,
   input  logic                  m_pslverr,
   output logic [DENY_CNT_W-1:0] deny_cnt,
   output logic                  auth_err,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   localparam logic [7:0]            TIMEOUT_L = 8'(TIMEOUT);
   localparam logic [DENY_CNT_W-1:0] CNT_MAX   = {DENY_CNT_W{1'b1}};

   logic dbgen_s;
   logic niden_s;
   logic setup_s;
   logic invasive_s;
   logic allow_s;

   state_e                state_d, state_q;
   logic [7:0]            tmo_d, tmo_q;
   logic                  req_write_d, req_write_q;
   logic [AW-1:0]         req_addr_d, req_addr_q;
   logic [31:0]           req_wdata_d, req_wdata_q;
   logic                  m_psel_d, m_psel_q;
   logic                  m_penable_d, m_penable_q;
   logic                  m_pwrite_d, m_pwrite_q;
   logic [AW-1:0]         m_paddr_d, m_paddr_q;
   logic [31:0]           m_pwdata_d, m_pwdata_q;
   logic                  s_pready_d, s_pready_q;
   logic                  s_pslverr_d, s_pslverr_q;
   logic [31:0]           s_prdata_d, s_prdata_q;
   logic [DENY_CNT_W-1:0] deny_cnt_d, deny_cnt_q;
   logic                  auth_err_d, auth_err_q;
   logic                  timeout_err_d, timeout_err_q;

   dw_dbp_sync2 u_sync_dbgen (.clk(clk), .rst_n(dbg_apb_presetn), .d(dbg_apb_dbgen), .q(dbgen_s));
   dw_dbp_sync2 u_sync_niden (.clk(clk), .rst_n(dbg_apb_presetn), .d(dbg_apb_niden), .q(niden_s));

   assign setup_s    = s_psel & ~s_penable;
   assign invasive_s = s_pwrite | ((s_paddr & INV_MASK) == INV_MATCH);
   assign allow_s    = invasive_s ? dbgen_s : (dbgen_s | niden_s);

   // next state and the registered response/forwarding values; outputs are
   // computed one cycle ahead so every port comes straight from a flop
   always_comb begin
      state_d       = state_q;
      tmo_d         = 8'd0;
      req_write_d   = req_write_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      m_psel_d      = 1'b0;
      m_penable_d   = 1'b0;
      s_pready_d    = 1'b0;
      s_pslverr_d   = 1'b0;
      s_prdata_d    = 32'h0000_0000;
      deny_cnt_d    = deny_cnt_q;
      auth_err_d    = auth_err_q;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (setup_s) begin
               req_write_d = s_pwrite;
               req_addr_d  = s_paddr;
               req_wdata_d = s_pwdata;
               if (allow_s) begin
                  state_d  = S_FSETUP;
                  m_psel_d = 1'b1;
               end else begin
                  state_d     = S_DENY;
                  s_pready_d  = 1'b1;
                  s_pslverr_d = 1'b1;
                  s_prdata_d  = DENY_RDATA;
                  auth_err_d  = 1'b1;
                  if (deny_cnt_q != CNT_MAX) begin
                     deny_cnt_d = deny_cnt_q + {{(DENY_CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     deny_cnt_d = deny_cnt_q;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FSETUP: begin
            state_d     = S_FACC;
            m_psel_d    = 1'b1;
            m_penable_d = 1'b1;
         end
         S_FACC: begin
            tmo_d = tmo_q + 8'd1;
            // once the budget is spent the bus is already released, so a
            // late m_pready is not trusted
            if (tmo_q == TIMEOUT_L) begin
               state_d       = S_RESP;
               tmo_d         = 8'd0;
               s_pready_d    = 1'b1;
               s_pslverr_d   = 1'b1;
               timeout_err_d = 1'b1;
            end else if (m_pready) begin
               state_d     = S_RESP;
               tmo_d       = 8'd0;
               s_pready_d  = 1'b1;
               s_pslverr_d = m_pslverr;
               s_prdata_d  = req_write_q ? 32'h0000_0000 : m_prdata;
            end else if (tmo_d == TIMEOUT_L) begin
               state_d = S_FACC;
            end else begin
               m_psel_d    = 1'b1;
               m_penable_d = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_DENY:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (err_clr) begin
         deny_cnt_d    = {DENY_CNT_W{1'b0}};
         auth_err_d    = 1'b0;
         timeout_err_d = 1'b0;
      end else begin
         deny_cnt_d    = deny_cnt_d;
      end

      m_pwrite_d = m_psel_d ? req_write_d : 1'b0;
      m_paddr_d  = m_psel_d ? req_addr_d  : {AW{1'b0}};
      m_pwdata_d = m_psel_d ? req_wdata_d : 32'h0000_0000;
   end

   // state, capture, status and output registers
   always_ff @(posedge clk or negedge dbg_apb_presetn) begin
      if (!dbg_apb_presetn) begin
         state_q       <= S_IDLE;
         tmo_q         <= 8'd0;
         req_write_q   <= 1'b0;
         req_addr_q    <= {AW{1'b0}};
         req_wdata_q   <= 32'h0000_0000;
         m_psel_q      <= 1'b0;
         m_penable_q   <= 1'b0;
         m_pwrite_q    <= 1'b0;
         m_paddr_q     <= {AW{1'b0}};
         m_pwdata_q    <= 32'h0000_0000;
         s_pready_q    <= 1'b0;
         s_pslverr_q   <= 1'b0;
         s_prdata_q    <= 32'h0000_0000;
         deny_cnt_q    <= {DENY_CNT_W{1'b0}};
         auth_err_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         req_write_q   <= req_write_d;
         req_addr_q    <= req_addr_d;
         req_wdata_q   <= req_wdata_d;
         m_psel_q      <= m_psel_d;
         m_penable_q   <= m_penable_d;
         m_pwrite_q    <= m_pwrite_d;
         m_paddr_q     <= m_paddr_d;
         m_pwdata_q    <= m_pwdata_d;
         s_pready_q    <= s_pready_d;
         s_pslverr_q   <= s_pslverr_d;
         s_prdata_q    <= s_prdata_d;
         deny_cnt_q    <= deny_cnt_d;
         auth_err_q    <= auth_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign m_psel      = m_psel_q;
   assign m_penable   = m_penable_q;
   assign m_pwrite    = m_pwrite_q;
   assign m_paddr     = m_paddr_q;
   assign m_pwdata    = m_pwdata_q;
   assign s_pready    = s_pready_q;
   assign s_pslverr   = s_pslverr_q;
   assign s_prdata    = s_prdata_q;
   assign deny_cnt    = deny_cnt_q;
   assign auth_err    = auth_err_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dw_dbp_apb_auth_gate.sv
// Directed self-checking bench for the debug-APB authentication gate.
module tb_dw_dbp_apb_auth_gate;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dbgen, niden;
   logic        s_psel, s_penable, s_pwrite;
   logic [11:0] s_paddr;
   logic [31:0] s_pwdata;
   logic [31:0] s_prdata;
   logic        s_pready, s_pslverr;
   logic        m_psel, m_penable, m_pwrite;
   logic [11:0] m_paddr;
   logic [31:0] m_pwdata;
   logic [31:0] m_prdata;
   logic        m_pready, m_pslverr;
   logic [7:0]  deny_cnt;
   logic        auth_err, timeout_err, err_clr;

   int n_tests = 0;
   int n_fail  = 0;

   dw_dbp_apb_auth_gate dut (
      .clk(clk), .dbg_apb_presetn(rst_n),
      .dbg_apb_dbgen(dbgen), .dbg_apb_niden(niden),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata),
      .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .deny_cnt(deny_cnt), .auth_err(auth_err), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_enables(input logic de, input logic ne);
      dbgen = de;
      niden = ne;
      repeat (3) tick();
   endtask

   // drive a setup phase and step into T1; master moves to access phase
   task automatic setup_xfer(input logic w, input logic [11:0] a, input logic [31:0] d);
      s_psel = 1'b1; s_penable = 1'b0; s_pwrite = w; s_paddr = a; s_pwdata = d;
      tick();
      s_penable = 1'b1;
   endtask

   task automatic end_xfer();
      s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0; m_pslverr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({s_pready, s_pslverr, m_psel, m_penable, m_pwrite, auth_err, timeout_err} !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl got %b exp 0000000",
            {s_pready, s_pslverr, m_psel, m_penable, m_pwrite, auth_err, timeout_err});
      end
      n_tests++;
      if (s_prdata !== 32'h0 || m_paddr !== 12'h0 || m_pwdata !== 32'h0 || deny_cnt !== 8'h0) begin
         n_fail++; $display("FAIL reset_data got %h %h %h %h exp zeros", s_prdata, m_paddr, m_pwdata, deny_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_allowed_write();
      set_enables(1'b1, 1'b1);
      m_prdata = 32'hFFFF_0000;
      setup_xfer(1'b1, 12'h004, 32'hDEADBEEF);
      n_tests++;
      if (m_psel !== 1'b1 || m_penable !== 1'b0) begin
         n_fail++; $display("FAIL wr_t1 got psel=%b pen=%b exp 1 0", m_psel, m_penable);
      end
      n_tests++;
      if (m_pwrite !== 1'b1 || m_paddr !== 12'h004 || m_pwdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL wr_fwd got w=%b a=%h d=%h exp 1 004 deadbeef", m_pwrite, m_paddr, m_pwdata);
      end
      m_pready = 1'b1;
      tick();
      n_tests++;
      if (m_psel !== 1'b1 || m_penable !== 1'b1 || s_pready !== 1'b0) begin
         n_fail++; $display("FAIL wr_t2 got psel=%b pen=%b rdy=%b exp 1 1 0", m_psel, m_penable, s_pready);
      end
      tick();
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b0 || s_prdata !== 32'h0 || m_psel !== 1'b0) begin
         n_fail++; $display("FAIL wr_t3 got rdy=%b err=%b d=%h psel=%b exp 1 0 0 0", s_pready, s_pslverr, s_prdata, m_psel);
      end
      end_xfer();
      tick();
      n_tests++;
      if (s_pready !== 1'b0) begin
         n_fail++; $display("FAIL wr_t4_rdy got %b exp 0", s_pready);
      end
   endtask

   task automatic test_noninvasive_read();
      set_enables(1'b0, 1'b1);
      setup_xfer(1'b0, 12'h104, 32'h0);
      n_tests++;
      if (m_psel !== 1'b1 || m_pwrite !== 1'b0 || m_paddr !== 12'h104) begin
         n_fail++; $display("FAIL rd_fwd got psel=%b w=%b a=%h exp 1 0 104", m_psel, m_pwrite, m_paddr);
      end
      m_prdata = 32'h12345678;
      m_pready = 1'b1;
      tick();
      tick();
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b0 || s_prdata !== 32'h12345678) begin
         n_fail++; $display("FAIL rd_resp got rdy=%b err=%b d=%h exp 1 0 12345678", s_pready, s_pslverr, s_prdata);
      end
      end_xfer();
      tick();
      setup_xfer(1'b0, 12'h010, 32'h0);
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || s_prdata !== 32'h0 || m_psel !== 1'b0) begin
         n_fail++; $display("FAIL inv_rd_deny got rdy=%b err=%b d=%h psel=%b exp 1 1 0 0", s_pready, s_pslverr, s_prdata, m_psel);
      end
      end_xfer();
      tick();
      n_tests++;
      if (deny_cnt !== 8'd1 || auth_err !== 1'b1 || s_pready !== 1'b0) begin
         n_fail++; $display("FAIL inv_rd_status got cnt=%0d auth=%b rdy=%b exp 1 1 0", deny_cnt, auth_err, s_pready);
      end
   endtask

   task automatic test_denied_write();
      logic psel_seen;
      int   rdy_cnt;
      psel_seen = 1'b0;
      rdy_cnt   = 0;
      setup_xfer(1'b1, 12'h104, 32'h55AA55AA);
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || m_psel !== 1'b0) begin
         n_fail++; $display("FAIL wr_deny got rdy=%b err=%b psel=%b exp 1 1 0", s_pready, s_pslverr, m_psel);
      end
      end_xfer();
      tick();
      n_tests++;
      if (deny_cnt !== 8'd2) begin
         n_fail++; $display("FAIL wr_deny_cnt got %0d exp 2", deny_cnt);
      end
      // back-to-back denials, each new setup in the first IDLE cycle
      for (int i = 0; i < 300; i++) begin
         setup_xfer(1'b1, 12'h104, i);
         if (m_psel) psel_seen = 1'b1;
         if (s_pready && s_pslverr) rdy_cnt++;
         end_xfer();
         tick();
         if (m_psel) psel_seen = 1'b1;
      end
      n_tests++;
      if (psel_seen !== 1'b0 || rdy_cnt != 300) begin
         n_fail++; $display("FAIL b2b_deny got psel_seen=%b responses=%0d exp 0 300", psel_seen, rdy_cnt);
      end
      n_tests++;
      if (deny_cnt !== 8'hFF || auth_err !== 1'b1) begin
         n_fail++; $display("FAIL deny_sat got cnt=%h auth=%b exp ff 1", deny_cnt, auth_err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_tests++;
      if (deny_cnt !== 8'h00 || auth_err !== 1'b0) begin
         n_fail++; $display("FAIL err_clr got cnt=%h auth=%b exp 00 0", deny_cnt, auth_err);
      end
      // clear coincident with a new deny: the deny must not be counted
      err_clr = 1'b1;
      setup_xfer(1'b1, 12'h104, 32'h0);
      err_clr = 1'b0;
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b1) begin
         n_fail++; $display("FAIL clr_deny_resp got rdy=%b err=%b exp 1 1", s_pready, s_pslverr);
      end
      end_xfer();
      tick();
      n_tests++;
      if (deny_cnt !== 8'h00 || auth_err !== 1'b0) begin
         n_fail++; $display("FAIL clr_wins got cnt=%h auth=%b exp 00 0", deny_cnt, auth_err);
      end
   endtask

   task automatic test_timeout();
      int acc;
      acc = 0;
      set_enables(1'b1, 1'b1);
      m_prdata = 32'hAAAA5555;
      m_pready = 1'b0;
      setup_xfer(1'b0, 12'h200, 32'h0);
      for (int i = 0; i < 600; i++) begin
         tick();
         if (m_penable === 1'b1) acc++;
         else break;
      end
      n_tests++;
      if (acc != 255) begin
         n_fail++; $display("FAIL tmo_cycles got %0d exp 255", acc);
      end
      n_tests++;
      if (m_psel !== 1'b0 || s_pready !== 1'b0) begin
         n_fail++; $display("FAIL tmo_drop got psel=%b rdy=%b exp 0 0", m_psel, s_pready);
      end
      tick();
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || s_prdata !== 32'h0 || timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL tmo_resp got rdy=%b err=%b d=%h terr=%b exp 1 1 0 1", s_pready, s_pslverr, s_prdata, timeout_err);
      end
      end_xfer();
      tick();
   endtask

   task automatic test_enable_drop_and_reset();
      setup_xfer(1'b1, 12'h008, 32'h0BADF00D);
      tick();
      dbgen = 1'b0;
      niden = 1'b0;
      repeat (2) tick();
      n_tests++;
      if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_pwdata !== 32'h0BADF00D) begin
         n_fail++; $display("FAIL drop_hold got psel=%b pen=%b d=%h exp 1 1 0badf00d", m_psel, m_penable, m_pwdata);
      end
      m_pready = 1'b1;
      tick();
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b0) begin
         n_fail++; $display("FAIL drop_resp got rdy=%b err=%b exp 1 0", s_pready, s_pslverr);
      end
      end_xfer();
      tick();
      set_enables(1'b1, 1'b1);
      setup_xfer(1'b1, 12'h00C, 32'h11112222);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({m_psel, m_penable, m_pwrite, s_pready, s_pslverr} !== 5'b0 || m_paddr !== 12'h0 || m_pwdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid got ctrl=%b a=%h d=%h exp 0", {m_psel, m_penable, m_pwrite, s_pready, s_pslverr}, m_paddr, m_pwdata);
      end
      end_xfer();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      setup_xfer(1'b1, 12'h010, 32'hCAFEF00D);
      n_tests++;
      if (m_psel !== 1'b1 || m_paddr !== 12'h010 || m_pwdata !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL post_rst_fwd got psel=%b a=%h d=%h exp 1 010 cafef00d", m_psel, m_paddr, m_pwdata);
      end
      m_pready = 1'b1;
      tick();
      tick();
      n_tests++;
      if (s_pready !== 1'b1 || s_pslverr !== 1'b0) begin
         n_fail++; $display("FAIL post_rst_resp got rdy=%b err=%b exp 1 0", s_pready, s_pslverr);
      end
      end_xfer();
      tick();
   endtask

   initial begin
      rst_n = 1'b0; dbgen = 1'b0; niden = 1'b0; err_clr = 1'b0;
      s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 12'h0; s_pwdata = 32'h0;
      m_prdata = 32'h0; m_pready = 1'b0; m_pslverr = 1'b0;
      #3;
      test_reset();
      test_allowed_write();
      test_noninvasive_read();
      test_denied_write();
      test_timeout();
      test_enable_drop_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
